mem_access_unit: RTL and testbench

Parametrised successor to the fixed MAR/MDR/RAM path in the single-bus CPU datapath. The block holds MAR and MDR and runs a handshaked read or write against a variable-latency memory. A start/busy/done interface lets the control unit stall on memory, and a timeout counter flags memories that never respond. It sits between the shared bus (bus_data in, MDR_data_out to the bus mux) and the memory port.

---
 rtl/mem_access_unit.sv | 112 +++++++++++
 tb/tb_mem_access_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MAR/MDR holder that runs one handshaked read or write against a variable-latency memory.
// Request visible the cycle after start; done pulses one cycle after ready or timeout; control inputs ignored while busy.
// Backpressure: mem_ready stalls the request state; the control unit stalls on busy.
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [DATA_W-1:0] bus_data,
    input  logic              MAR_enable,
    input  logic              MDR_enable,
    input  logic              start_read,
    input  logic              start_write,
    output logic [DATA_W-1:0] MAR_data_out,
    output logic [DATA_W-1:0] MDR_data_out,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int              CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit              TMO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  mar, mar_nxt;
    logic [DATA_W-1:0]  mdr, mdr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               err_q, err_nxt;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mar_nxt   = mar;
        mdr_nxt   = mdr;
        cnt_nxt   = cnt;
        err_nxt   = err_q;
        case (state)
            S_IDLE: begin
                // Loads and start share the edge, so the transaction sees the freshly loaded registers.
                if (MAR_enable) mar_nxt = bus_data;
                if (MDR_enable) mdr_nxt = bus_data;
                if (start_read || start_write) begin
                    state_nxt = start_read ? S_READ : S_WRITE;
                    cnt_nxt   = '0;
                    err_nxt   = 1'b0;
                end
            end
            S_READ, S_WRITE: begin
                if (mem_ready) begin
                    if (state == S_READ) mdr_nxt = mem_rdata;
                    state_nxt = S_DONE;
                end else if (TMO_EN && (cnt == CNT_LAST)) begin
                    err_nxt   = 1'b1;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            mar   <= '0;
            mdr   <= '0;
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            mar   <= mar_nxt;
            mdr   <= mdr_nxt;
            cnt   <= cnt_nxt;
            err_q <= err_nxt;
        end
    end

    assign MAR_data_out = mar;
    assign MDR_data_out = mdr;
    assign busy         = (state != S_IDLE);
    assign done         = (state == S_DONE);
    assign err          = err_q;
    assign mem_addr     = mar[ADDR_W-1:0];
    assign mem_wdata    = mdr;
    assign mem_re       = (state == S_READ);
    assign mem_we       = (state == S_WRITE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model compared every cycle, directed cases plus random traffic.
module tb_mem_access_unit;
    localparam int DW = 32;
    localparam int AW = 8;
    localparam int TO = 4;

    logic          clock;
    logic          clear;
    logic [DW-1:0] bus_data;
    logic          MAR_enable, MDR_enable, start_read, start_write;
    logic [DW-1:0] MAR_data_out, MDR_data_out;
    logic          busy, done, err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_re, mem_we;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    mem_access_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clock(clock), .clear(clear), .bus_data(bus_data),
        .MAR_enable(MAR_enable), .MDR_enable(MDR_enable),
        .start_read(start_read), .start_write(start_write),
        .MAR_data_out(MAR_data_out), .MDR_data_out(MDR_data_out),
        .busy(busy), .done(done), .err(err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Model: one transaction = accept edge, n_req request cycles, one done cycle.
    logic [DW-1:0] m_mar, m_mdr, m_rd;
    logic          m_err, m_active, m_read, m_to;
    int            m_age, m_lat, m_nreq;

    int            next_lat;
    logic [DW-1:0] rd_value;
    int            cyc, start_cyc, done_cyc;
    int            re_cnt, we_cnt, done_cnt;
    logic [AW-1:0] last_re_addr, last_we_addr;
    logic [DW-1:0] last_we_data;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mar = '0; m_mdr = '0; m_err = 1'b0; m_active = 1'b0;
        m_read = 1'b0; m_to = 1'b0; m_age = 0; m_lat = 0; m_nreq = 0; m_rd = '0;
    endtask

    task automatic model_step();
        if (!clear) begin
            model_reset();
        end else if (!m_active) begin
            if (MAR_enable) m_mar = bus_data;
            if (MDR_enable) m_mdr = bus_data;
            if (start_read || start_write) begin
                m_active = 1'b1;
                m_read   = start_read;
                m_age    = 1;
                m_lat    = next_lat;
                m_rd     = rd_value;
                m_to     = (TO != 0) && (next_lat >= TO);
                m_nreq   = m_to ? TO : next_lat + 1;
                m_err    = 1'b0;
            end
        end else if (m_age == m_nreq) begin
            if (m_to) m_err = 1'b1;
            else if (m_read) m_mdr = m_rd;
            m_age++;
        end else if (m_age > m_nreq) begin
            m_active = 1'b0;
        end else begin
            m_age++;
        end
    endtask

    task automatic set_mem();
        if (m_active && m_age <= m_nreq) mem_ready = (m_age == m_lat + 1);
        else mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = mem_ready ? (m_active ? m_rd : $urandom) : $urandom;
    endtask

    task automatic compare();
        logic req, dn;
        req = m_active && (m_age <= m_nreq);
        dn  = m_active && (m_age > m_nreq);
        chk("busy",      {31'd0, busy},   {31'd0, m_active});
        chk("done",      {31'd0, done},   {31'd0, dn});
        chk("err",       {31'd0, err},    {31'd0, m_err});
        chk("mem_re",    {31'd0, mem_re}, {31'd0, req && m_read});
        chk("mem_we",    {31'd0, mem_we}, {31'd0, req && !m_read});
        chk("MAR",       MAR_data_out,    m_mar);
        chk("MDR",       MDR_data_out,    m_mdr);
        chk("mem_addr",  {24'd0, mem_addr}, {24'd0, m_mar[AW-1:0]});
        chk("mem_wdata", mem_wdata,       m_mdr);
        if (mem_re) begin re_cnt++; last_re_addr = mem_addr; end
        if (mem_we) begin we_cnt++; last_we_addr = mem_addr; last_we_data = mem_wdata; end
        if (done) begin done_cnt++; done_cyc = cyc; end
    endtask

    task automatic cycle();
        set_mem();
        @(negedge clock);
        compare();
        @(posedge clock);
        model_step();
        #1;
        cyc++;
        MAR_enable = 1'b0; MDR_enable = 1'b0; start_read = 1'b0; start_write = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clr_counts();
        re_cnt = 0; we_cnt = 0; done_cnt = 0; done_cyc = -1;
    endtask

    initial begin
        cyc = 0; next_lat = 0; rd_value = '0;
        bus_data = '0; MAR_enable = 0; MDR_enable = 0; start_read = 0; start_write = 0;
        mem_ready = 0; mem_rdata = '0;
        clr_counts();
        clear = 1'b0;
        model_reset();
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_MDR",  MDR_data_out, 32'd0);
        chk("rst_err",  {31'd0, err}, 32'd0);
        run(2);
        clear = 1'b1;

        // Reset mid-read aborts without a done pulse
        bus_data = 32'h33; MAR_enable = 1; cycle();
        bus_data = 32'h77; MDR_enable = 1; cycle();
        next_lat = 99; start_read = 1; cycle();
        run(2);
        clr_counts();
        clear = 1'b0;
        model_reset();
        #1;
        chk("arst_busy",   {31'd0, busy},   32'd0);
        chk("arst_mem_re", {31'd0, mem_re}, 32'd0);
        chk("arst_MDR",    MDR_data_out,    32'd0);
        chk("arst_MAR",    MAR_data_out,    32'd0);
        cycle();
        clear = 1'b1;
        run(3);
        chk("arst_no_done", done_cnt, 0);

        // Zero-wait write
        bus_data = 32'h05; MAR_enable = 1; cycle();
        bus_data = 32'hDEADBEEF; MDR_enable = 1; cycle();
        clr_counts();
        next_lat = 0; start_write = 1; start_cyc = cyc; cycle();
        run(3);
        chk("wr_we_cycles", we_cnt, 1);
        chk("wr_addr",      {24'd0, last_we_addr}, 32'h05);
        chk("wr_data",      last_we_data, 32'hDEADBEEF);
        chk("wr_done_lat",  done_cyc - start_cyc, 2);
        chk("wr_err",       {31'd0, err}, 32'd0);

        // Read, ready on third request cycle
        bus_data = 32'h0; MDR_enable = 1; cycle();
        clr_counts();
        next_lat = 2; rd_value = 32'hDEADBEEF; start_read = 1; start_cyc = cyc; cycle();
        run(5);
        chk("rd_re_cycles", re_cnt, 3);
        chk("rd_mdr",       MDR_data_out, 32'hDEADBEEF);
        chk("rd_done_lat",  done_cyc - start_cyc, 4);

        // Timeout: exactly TO request cycles, err set, MDR kept
        clr_counts();
        next_lat = 99; rd_value = 32'h1111_2222; start_read = 1; start_cyc = cyc; cycle();
        run(6);
        chk("to_re_cycles", re_cnt, 4);
        chk("to_err",       {31'd0, err}, 32'd1);
        chk("to_mdr",       MDR_data_out, 32'hDEADBEEF);
        chk("to_done_lat",  done_cyc - start_cyc, 5);
        next_lat = 0; rd_value = 32'h0BADF00D; start_read = 1; cycle();
        chk("to_err_clr",   {31'd0, err}, 32'd0);
        run(3);

        // Read wins over write; MAR load in the same cycle is used
        clr_counts();
        next_lat = 0; rd_value = 32'h0000_4242;
        bus_data = 32'h12; MAR_enable = 1; start_read = 1; start_write = 1; cycle();
        run(3);
        chk("both_re_cycles", re_cnt, 1);
        chk("both_we_cycles", we_cnt, 0);
        chk("both_addr",      {24'd0, last_re_addr}, 32'h12);

        // Inputs ignored while busy; start in following idle accepted
        clr_counts();
        next_lat = 1; rd_value = 32'hA5A5A5A5; start_read = 1; cycle();
        next_lat = 0;
        bus_data = 32'h1; MDR_enable = 1; start_write = 1; cycle();
        bus_data = 32'h1; MDR_enable = 1; start_write = 1; cycle();
        start_read = 1; cycle();
        chk("busy_mdr", MDR_data_out, 32'hA5A5A5A5);
        start_write = 1; cycle();
        run(3);
        chk("busy_re_cycles", re_cnt, 2);
        chk("busy_we_cycles", we_cnt, 1);
        chk("busy_done_cnt",  done_cnt, 2);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bus_data    = $urandom;
            MAR_enable  = ($urandom_range(0, 3) == 0);
            MDR_enable  = ($urandom_range(0, 3) == 0);
            start_read  = ($urandom_range(0, 3) == 0);
            start_write = ($urandom_range(0, 3) == 0);
            next_lat    = $urandom_range(0, 6);
            rd_value    = $urandom;
            if ($urandom_range(0, 199) == 0) begin
                clear = 1'b0;
                model_reset();
                #1;
                cycle();
                clear = 1'b1;
            end else begin
                cycle();
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
